// File: rtl/pixel_ram_responder_if.sv
// pixel_ram_responder_if: processing-module RAM port (step handshake plus arbitration hold).
`default_nettype none
`timescale 1ns/1ps

interface pixel_ram_responder_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
);
  logic              wren;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_write;
  logic              ext_hold;
  logic [DATA_W-1:0] data_read;
  logic              pause;

  modport master (
    output wren, address, data_write, ext_hold,
    input  data_read, pause
  );

  modport slave (
    input  wren, address, data_write, ext_hold,
    output data_read, pause
  );
endinterface

`default_nettype wire

// File: rtl/pixel_ram_responder.sv
// pixel_ram_responder: turns each processing-module step into one async SRAM access, throttled by pause.
// Optional macro SRAM_WRITE_VERIFY_EN adds a read-back compare after every write (sticky verify_error).
`default_nettype none
`timescale 1ns/1ps

module pixel_ram_responder #(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 32
) (
  input  wire logic              clk_div_by_two,
  input  wire logic              reset,
  pixel_ram_responder_if.slave   bus,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic [DATA_W-1:0]      sram_wdata,
  input  wire logic [DATA_W-1:0] sram_rdata,
  output logic                   sram_drive,
  output logic                   sram_ce_n,
  output logic                   sram_we_n,
  output logic                   sram_oe_n,
  output logic                   verify_error
);

  localparam logic [3:0] c_WAIT = 4'(WAIT_STATES);

`ifdef SRAM_WRITE_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_STROBE, S_CAPTURE, S_ACCESS, S_FINISH, S_VERIFY_RD, S_VERIFY_CMP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_STROBE, S_CAPTURE, S_ACCESS, S_FINISH
  } state_t;
`endif

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_wren;
  logic              r_pause;
  logic [DATA_W-1:0] r_data_read;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [DATA_W-1:0] r_sram_wdata;
  logic              r_drive;
  logic              r_ce_n;
  logic              r_we_n;
  logic              r_oe_n;
`ifdef SRAM_WRITE_VERIFY_EN
  logic [DATA_W-1:0] r_vdata;
  logic              r_verify_error;
`endif

  always_ff @(posedge clk_div_by_two) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_wren       <= 1'b0;
      r_pause      <= 1'b1;
      r_data_read  <= '0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_drive      <= 1'b0;
      r_ce_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_oe_n       <= 1'b1;
`ifdef SRAM_WRITE_VERIFY_EN
      r_vdata        <= '0;
      r_verify_error <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!bus.ext_hold) begin
            r_pause <= 1'b0;
            r_state <= S_STROBE;
          end
        end
        S_STROBE: begin
          r_pause <= 1'b1;
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_wren      <= bus.wren;
          r_sram_addr <= bus.address;
          r_ce_n      <= 1'b0;
          r_cnt       <= c_WAIT;
          if (bus.wren) begin
            r_drive      <= 1'b1;
            r_sram_wdata <= bus.data_write;
            r_we_n       <= 1'b0;
          end else begin
            r_oe_n <= 1'b0;
          end
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            if (!r_wren) r_data_read <= sram_rdata;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          // Address stays put this cycle so the strobe edge meets SRAM hold time.
          r_drive <= 1'b0;
`ifdef SRAM_WRITE_VERIFY_EN
          if (r_wren) begin
            r_oe_n  <= 1'b0;
            r_cnt   <= c_WAIT;
            r_state <= S_VERIFY_RD;
          end else begin
            r_ce_n  <= 1'b1;
            r_state <= S_IDLE;
          end
`else
          r_ce_n  <= 1'b1;
          r_state <= S_IDLE;
`endif
        end
`ifdef SRAM_WRITE_VERIFY_EN
        S_VERIFY_RD: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_vdata <= sram_rdata;
            r_oe_n  <= 1'b1;
            r_state <= S_VERIFY_CMP;
          end
        end
        S_VERIFY_CMP: begin
          if (r_vdata != r_sram_wdata) r_verify_error <= 1'b1;
          r_ce_n  <= 1'b1;
          r_state <= S_IDLE;
        end
`endif
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.pause     = r_pause;
  assign bus.data_read = r_data_read;
  assign sram_addr     = r_sram_addr;
  assign sram_wdata    = r_sram_wdata;
  assign sram_drive    = r_drive;
  assign sram_ce_n     = r_ce_n;
  assign sram_we_n     = r_we_n;
  assign sram_oe_n     = r_oe_n;
`ifdef SRAM_WRITE_VERIFY_EN
  assign verify_error  = r_verify_error;
`else
  assign verify_error  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pixel_ram_responder.sv
// tb_pixel_ram_responder: directed steps with a scoreboard on data_read plus SRAM-pin protocol monitors.
`default_nettype none
`timescale 1ns/1ps

module tb_pixel_ram_responder;
  localparam int W  = 2;
  localparam int AW = 18;
  localparam int DW = 32;
`ifdef SRAM_WRITE_VERIFY_EN
  localparam logic [31:0] MASK   = 32'hFFFF_FFFE;
  localparam int          WR_LEN = 2*W + 5;
  localparam logic        EXP_VE = 1'b1;
`else
  localparam logic [31:0] MASK   = 32'hFFFF_FFFF;
  localparam int          WR_LEN = W + 4;
  localparam logic        EXP_VE = 1'b0;
`endif
  localparam int RD_LEN = W + 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pixel_ram_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic          sram_drive, sram_ce_n, sram_we_n, sram_oe_n, verify_error;

  pixel_ram_responder #(.WAIT_STATES(W), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_div_by_two (clk),
    .reset          (rst),
    .bus            (bus.slave),
    .sram_addr      (sram_addr),
    .sram_wdata     (sram_wdata),
    .sram_rdata     (sram_rdata),
    .sram_drive     (sram_drive),
    .sram_ce_n      (sram_ce_n),
    .sram_we_n      (sram_we_n),
    .sram_oe_n      (sram_oe_n),
    .verify_error   (verify_error)
  );

  // Async SRAM pin model (bit0 stuck at 0 when the verify feature is built)
  logic [31:0] sram_mem [0:(1<<AW)-1];
  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n && sram_drive) sram_mem[sram_addr] = sram_wdata & MASK;
  assign sram_rdata = (!sram_ce_n && !sram_oe_n && !sram_drive) ? sram_mem[sram_addr] : 32'hDEAD_BEEF;

  int n_checks = 0;
  int n_pass   = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic          wren;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            hold;
  } step_t;

  logic [31:0]   ref_mem [logic [AW-1:0]];
  logic [31:0]   exp_q [$];
  logic [31:0]   last_rd = 32'h0;
  logic          last_wren = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_data = '0;
  int            hold_cnt = 0;

  function automatic logic [31:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 32'h0;
  endfunction

  task automatic wait_strobe(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.pause !== 1'b0 && n < 100);
    if (bus.pause !== 1'b0) chk({name, "_timeout"}, 32'(n), 32'(0));
  endtask

  // Driver: plays the processing module, one step per observed strobe
  initial begin
    step_t steps[$];
    int n;
    logic ok;
    steps.push_back('{1'b1, 18'd2240,  32'h0000_0001, 1'b0});
    steps.push_back('{1'b0, 18'd2241,  32'h0,         1'b0});
    steps.push_back('{1'b1, 18'd74560, 32'h0000_0005, 1'b0});
    steps.push_back('{1'b0, 18'd74560, 32'h0,         1'b0});
    steps.push_back('{1'b1, 18'h3FFFF, 32'hA5A5_0F0F, 1'b0});
    steps.push_back('{1'b0, 18'h3FFFF, 32'h0,         1'b1});
    steps.push_back('{1'b0, 18'd2240,  32'h0,         1'b0});
    steps.push_back('{1'b0, 18'd74560, 32'h0,         1'b0});

    sram_mem[2241] = 32'hFFFF_FFFF;
    ref_mem[18'd2241] = 32'hFFFF_FFFF;
    bus.wren = 1'b0; bus.address = '0; bus.data_write = '0; bus.ext_hold = 1'b0;
    rst = 1'b1;

    repeat (3) begin
      @(negedge clk);
      chk("reset_ctl", {27'd0, bus.pause, sram_ce_n, sram_we_n, sram_oe_n, sram_drive}, {27'd0, 5'b11110});
      chk("reset_data_read", bus.data_read, 32'h0);
      chk("reset_addr_ve", {13'd0, sram_addr, verify_error}, 32'h0);
    end
    rst = 1'b0;

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.pause !== 1'b0 && n < 10);
    chk("first_strobe_delay", 32'(n >= 1 && n <= 2), 32'd1);

    foreach (steps[i]) begin
      @(posedge clk);
      #1;
      bus.wren = steps[i].wren;
      bus.address = steps[i].addr;
      bus.data_write = steps[i].data;
      cur_addr = steps[i].addr;
      cur_data = steps[i].data;
      last_wren = steps[i].wren;
      if (steps[i].wren) ref_mem[steps[i].addr] = steps[i].data & MASK;
      else last_rd = ref_rd(steps[i].addr);
      exp_q.push_back(last_rd);

      if (steps[i].hold) begin
        repeat (2) @(negedge clk);
        bus.ext_hold = 1'b1;
        hold_cnt++;
        ok = 1'b1;
        repeat (20) begin
          @(negedge clk);
          if (bus.pause !== 1'b1) ok = 1'b0;
        end
        chk("hold_pause_high", 32'(ok), 32'd1);
        bus.ext_hold = 1'b0;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (bus.pause !== 1'b0 && n < 10);
        chk("hold_release_delay", 32'(n >= 1 && n <= 2), 32'd1);
      end else begin
        wait_strobe("step");
      end
    end

    repeat (2) @(posedge clk);
    #1;
    chk("verify_error", 32'(verify_error), 32'(EXP_VE));
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Scoreboard monitor: each strobe presents the read data owed by the previous step
  int iv_cnt = 0;
  int hold_seen = 0;
  bit seen_strobe = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      iv_cnt++;
      if (bus.pause === 1'b0) begin
        if (exp_q.size() > 0) chk("data_read", bus.data_read, exp_q.pop_front());
        if (seen_strobe && hold_seen == hold_cnt)
          chk("strobe_interval", 32'(iv_cnt), 32'(last_wren ? WR_LEN : RD_LEN));
        hold_seen = hold_cnt;
        seen_strobe = 1'b1;
        iv_cnt = 0;
      end
    end
  end

  // SRAM pin protocol monitor
  int we_cnt = 0;
  int oe_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (sram_we_n === 1'b0) we_cnt++;
      else if (we_cnt != 0) begin
        chk("we_low_cycles", 32'(we_cnt), 32'(W));
        we_cnt = 0;
      end
      if (sram_oe_n === 1'b0) oe_cnt++;
      else if (oe_cnt != 0) begin
        chk("oe_low_cycles", 32'(oe_cnt), 32'(W));
        oe_cnt = 0;
      end
      if (sram_ce_n === 1'b0) begin
        chk("sram_addr_stable", {14'd0, sram_addr}, {14'd0, cur_addr});
        if (sram_oe_n === 1'b0) chk("drive_off_on_read", 32'(sram_drive), 32'd0);
        if (sram_drive === 1'b1) chk("sram_wdata_stable", sram_wdata, cur_data);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/pixel_ram_responder.md
Name: pixel_ram_responder

Overview:
- Memory-side responder for the frame-processing modules' RAM port: wren, address[17:0], data_write[31:0] in; data_read[31:0] and pause out.
- Converts each single-cycle step of a processing module into one complete access on the external single-port asynchronous SRAM.
- Throttles the processing module with pause so that data_read for the address issued at step n is valid at step n+1.
- Sits between the processing-module mux and the SRAM pins, clocked by clk_div_by_two.

Parameters:
- WAIT_STATES, 2, number of cycles WE_n/OE_n are held low per access (legal range 1..15).
- ADDR_W, 18, SRAM word address width.
- DATA_W, 32, SRAM word width.

Ports:
- clk_div_by_two  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- wren  in  1  write request from the processing module.
- address  in  ADDR_W  access address.
- data_write  in  DATA_W  write data.
- ext_hold  in  1  arbitration hold (camera/host); 1 = do not start a new step.
- data_read  out  DATA_W  registered read data.
- pause  out  1  registered; 0 only during the single strobe cycle.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data.
- sram_drive  out  1  1 = enable the data-bus tristate drivers.
- sram_ce_n  out  1  active-low chip enable.
- sram_we_n  out  1  active-low write enable.
- sram_oe_n  out  1  active-low output enable.
- verify_error  out  1  sticky write-verify failure flag.

Behaviour:
- Interface contract: one clock (clk_div_by_two); reset is synchronous and active-high.
- Reset values: state=IDLE, pause=1, data_read=0, sram_addr=0, sram_wdata=0, sram_drive=0, sram_ce_n=1, sram_we_n=1, sram_oe_n=1, verify_error=0.
- Reset asserted mid-access aborts the access. SRAM controls return to idle at that edge; a partially written word is undefined.
- IDLE: pause=1. If ext_hold=0, go to STROBE; otherwise stay in IDLE.
- STROBE: pause=0 for exactly one cycle, so the processing module steps exactly once and drives its next address, wren and data_write. Next state is CAPTURE, with pause<=1.
- CAPTURE:
  - Latch address/wren/data_write.
  - sram_addr<=address, sram_ce_n<=0.
  - Write: sram_drive<=1, sram_wdata<=data_write.
  - Read: sram_oe_n<=0.
  - cnt<=WAIT_STATES, go to ACCESS.
- ACCESS:
  - Write holds sram_we_n=0; read holds sram_oe_n=0. Decrement cnt each cycle.
  - When cnt==1 on a read, data_read<=sram_rdata; go to FINISH.
  - A write leaves data_read unchanged.
- FINISH: sram_we_n=1, sram_oe_n=1. Address and data are held one more cycle for hold time. Then sram_drive<=0, sram_ce_n<=1, go to IDLE.
- Throughput: one step per WAIT_STATES+4 cycles; 6 cycles at the default.
- Read-data timing: data_read is stable from FINISH until the next read's ACCESS completes.
- ext_hold sampled high in IDLE delays the strobe indefinitely.
- ext_hold asserted during CAPTURE, ACCESS or FINISH never interrupts the access in progress.
- The responder never issues a strobe while the SRAM bus is driven.
- Back-to-back accesses to the same address (read after write) return the freshly written value.
- address wraps naturally at 2^ADDR_W; there is no range checking.

Optional Feature:
- Macro: SRAM_WRITE_VERIFY_EN.
- Defined:
  - After each write's FINISH, insert VERIFY_RD (sram_oe_n=0 for WAIT_STATES cycles, same address, sram_drive=0).
  - Then VERIFY_CMP: if sram_rdata != latched data_write, verify_error<=1 (sticky until reset).
  - Then go to IDLE. Write steps take 2*WAIT_STATES+5 cycles; reads are unchanged.
- Not defined: no verify states; verify_error tied to 0.

Test Plan:
- Reset held 3 cycles, then released with ext_hold=0 -> pause=1, all SRAM controls high, data_read=0 during reset; first pause=0 strobe appears 2 cycles after release.
- Write address=2240, data_write=32'h1 with SRAM model -> sram_we_n low exactly 2 cycles, sram_addr/sram_wdata stable from CAPTURE through FINISH; next strobe 6 cycles after the previous one.
- Read of 2241 (preloaded 32'hFFFFFFFF) issued at strobe n -> data_read=32'hFFFFFFFF when pause next falls; sram_drive=0 throughout.
- Write 32'h5 to 74560, then read 74560 -> data_read=32'h5; address 18'h3FFFF accepted without error.
- ext_hold=1 asserted during ACCESS and held 20 cycles -> current access completes normally; pause stays 1 until 2 cycles after ext_hold falls.
- With SRAM_WRITE_VERIFY_EN, SRAM model forces bit0 stuck at 0, write 32'h1 -> verify_error=1 after VERIFY_CMP and stays 1; write step length = 9 cycles.
